// File: rtl/motor_sequencer_if.sv
// Job request/grant/status bundle between the requesters and motor_sequencer.
interface motor_sequencer_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [1:0]       REQ;
  logic [1:0]       REQ_DIR;
  logic [CNT_W-1:0] REQ_CNT0;
  logic [CNT_W-1:0] REQ_CNT1;
  logic             ABORT;
  logic [1:0]       GNT;
  logic             BUSY;
  logic             DONE;
  logic             DONE_ID;
  logic             ABORTED;
  logic [CNT_W-1:0] REMAIN;

  modport master (
    output REQ, REQ_DIR, REQ_CNT0, REQ_CNT1, ABORT,
    input  GNT, BUSY, DONE, DONE_ID, ABORTED, REMAIN
  );

  modport slave (
    input  REQ, REQ_DIR, REQ_CNT0, REQ_CNT1, ABORT,
    output GNT, BUSY, DONE, DONE_ID, ABORTED, REMAIN
  );
endinterface

// File: rtl/motor_sequencer.sv
// Two-port round-robin job sequencer driving a toggle-style stepper driver.
// Outputs are registered from the next-state decode so every pulse is glitch-free.
module motor_sequencer #(
  parameter int unsigned PERIOD_CYCLES = 960000,
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  motor_sequencer_if.slave  job,
  output logic              RUN_DIR,
  output logic              MOTOR_ON,
  output logic              MOTOR_DIR
);

  localparam int unsigned TmrMax   = (PERIOD_CYCLES > SETTLE_CYCLES) ? PERIOD_CYCLES
                                                                     : SETTLE_CYCLES;
  localparam int unsigned TmrW     = ($clog2(TmrMax) > 0) ? $clog2(TmrMax) : 1;
  localparam logic [TmrW-1:0] PeriodLast = TmrW'(PERIOD_CYCLES - 1);
  localparam logic [TmrW-1:0] SettleLast = TmrW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StGrant, StDirPulse, StSettle, StOnPulse, StRun, StOffPulse, StFinish
  } state_e;

  state_e           state_q, state_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             job_dir_q, job_dir_d;
  logic             job_id_q, job_id_d;
  logic             last_q, last_d;
  logic             abort_q, abort_d;
  logic             dir_sh_q, on_sh_q;
  logic [1:0]       gnt_q;
  logic             busy_q, done_q, done_id_q, aborted_q, mon_q, mdir_q;
  logic             win1;

  // Tie goes to the requester not granted last.
  assign win1 = job.REQ[1] & (~job.REQ[0] | ~last_q);

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q + TmrW'(1);
    remain_d  = remain_q;
    job_dir_d = job_dir_q;
    job_id_d  = job_id_q;
    last_d    = last_q;
    abort_d   = abort_q;
    case (state_q)
      StIdle: begin
        if (|job.REQ) begin
          state_d   = StGrant;
          job_id_d  = win1;
          last_d    = win1;
          job_dir_d = job.REQ_DIR[win1];
          remain_d  = win1 ? job.REQ_CNT1 : job.REQ_CNT0;
          abort_d   = 1'b0;
        end
      end
      StGrant: begin
        if (job.ABORT) begin
          abort_d = 1'b1;
          state_d = StFinish;
        end else if (remain_q == '0) begin
          state_d = StFinish;
        end else if (job_dir_q != dir_sh_q) begin
          state_d = StDirPulse;
        end else begin
          state_d = StOnPulse;
        end
      end
      StDirPulse: begin
        tmr_d = '0;
        if (job.ABORT) begin
          abort_d = 1'b1;
          state_d = StFinish;
        end else begin
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (job.ABORT) begin
          abort_d = 1'b1;
          state_d = StFinish;
        end else if (tmr_q == SettleLast) begin
          state_d = StOnPulse;
        end
      end
      StOnPulse: begin
        // An abort here is remembered and acted on from RUN, keeping a low cycle
        // between the ON and OFF toggles so the driver sees two distinct pulses.
        tmr_d   = '0;
        state_d = StRun;
        if (job.ABORT) abort_d = 1'b1;
      end
      StRun: begin
        if (job.ABORT || abort_q) begin
          abort_d = 1'b1;
          state_d = StOffPulse;
        end else if (tmr_q == PeriodLast) begin
          tmr_d    = '0;
          remain_d = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) state_d = StOffPulse;
        end
      end
      StOffPulse: state_d = StFinish;
      StFinish:   state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      tmr_q     <= '0;
      remain_q  <= '0;
      job_dir_q <= 1'b0;
      job_id_q  <= 1'b0;
      last_q    <= 1'b1;
      abort_q   <= 1'b0;
      dir_sh_q  <= 1'b0;
      on_sh_q   <= 1'b0;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      aborted_q <= 1'b0;
      mon_q     <= 1'b0;
      mdir_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      remain_q  <= remain_d;
      job_dir_q <= job_dir_d;
      job_id_q  <= job_id_d;
      last_q    <= last_d;
      abort_q   <= abort_d;
      gnt_q     <= (state_d == StGrant) ? (job_id_d ? 2'b10 : 2'b01) : 2'b00;
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_d == StFinish);
      mon_q     <= (state_d == StOnPulse) || (state_d == StOffPulse);
      mdir_q    <= (state_d == StDirPulse);
      if (state_d == StFinish) begin
        done_id_q <= job_id_d;
        aborted_q <= abort_d;
      end
      if (state_d == StDirPulse) dir_sh_q <= ~dir_sh_q;
      if (state_d == StOnPulse) on_sh_q <= 1'b1;
      else if (state_d == StOffPulse) on_sh_q <= 1'b0;
    end
  end

  assign job.GNT     = gnt_q;
  assign job.BUSY    = busy_q;
  assign job.DONE    = done_q;
  assign job.DONE_ID = done_id_q;
  assign job.ABORTED = aborted_q;
  assign job.REMAIN  = remain_q;
  assign RUN_DIR     = dir_sh_q;
  assign MOTOR_ON    = mon_q;
  assign MOTOR_DIR   = mdir_q;

  a_dir_only_when_off: assert property (@(posedge CLK) disable iff (RESET)
    MOTOR_DIR |-> !on_sh_q);
  a_pulses_exclusive: assert property (@(posedge CLK) disable iff (RESET)
    !(MOTOR_ON && MOTOR_DIR));
  a_on_single_cycle: assert property (@(posedge CLK) disable iff (RESET)
    MOTOR_ON |=> !MOTOR_ON);

endmodule

// File: tb/tb_motor_sequencer.sv
// Directed bench for motor_sequencer with PERIOD_CYCLES=8, SETTLE_CYCLES=3.
module tb_motor_sequencer;
  logic CLK;
  logic RESET;
  logic RUN_DIR, MOTOR_ON, MOTOR_DIR;
  int   total, bad;
  int   n_on, n_dir, n_done;

  motor_sequencer_if #(.CNT_W(16)) bus ();

  motor_sequencer #(
    .PERIOD_CYCLES(8),
    .SETTLE_CYCLES(3),
    .CNT_W        (16)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .job      (bus),
    .RUN_DIR  (RUN_DIR),
    .MOTOR_ON (MOTOR_ON),
    .MOTOR_DIR(MOTOR_DIR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance one cycle and sample #1 after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
    if (MOTOR_ON) n_on++;
    if (MOTOR_DIR) n_dir++;
    if (bus.DONE) n_done++;
  endtask

  task automatic request(input int id, input logic dir, input logic [15:0] cnt,
                         output int lat);
    bus.REQ_DIR[id] = dir;
    if (id == 0) bus.REQ_CNT0 = cnt;
    else bus.REQ_CNT1 = cnt;
    bus.REQ[id] = 1'b1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus.GNT != 2'b00) begin
        lat = i;
        break;
      end
    end
    bus.REQ[id] = 1'b0;
  endtask

  task automatic wait_on(output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (MOTOR_ON) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (bus.DONE) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic logic [25:0] all_outs();
    return {bus.GNT, bus.BUSY, bus.DONE, bus.DONE_ID, bus.ABORTED, bus.REMAIN,
            RUN_DIR, MOTOR_ON, MOTOR_DIR};
  endfunction

  task automatic test_reset();
    RESET = 1'b1;
    step();
    step();
    total++;
    if (all_outs() !== 26'd0) begin
      bad++;
      $display("FAIL reset_outs: got %h want 0", all_outs());
    end
    RESET = 1'b0;
    step();
    total++;
    if (bus.BUSY !== 1'b0 || bus.GNT !== 2'b00) begin
      bad++;
      $display("FAIL reset_idle: busy=%b gnt=%b want 0/00", bus.BUSY, bus.GNT);
    end
  endtask

  task automatic test_single_fwd();
    int lat;
    n_on = 0; n_dir = 0;
    request(0, 1'b0, 16'd2, lat);
    total++;
    if (lat !== 1 || bus.GNT !== 2'b01) begin
      bad++;
      $display("FAIL fwd_gnt: lat=%0d gnt=%b want 1/01", lat, bus.GNT);
    end
    total++;
    if (bus.REMAIN !== 16'd2 || bus.BUSY !== 1'b1) begin
      bad++;
      $display("FAIL fwd_latch: remain=%0d busy=%b want 2/1", bus.REMAIN, bus.BUSY);
    end
    step();
    total++;
    if (MOTOR_ON !== 1'b1 || MOTOR_DIR !== 1'b0) begin
      bad++;
      $display("FAIL fwd_on: on=%b dir=%b want 1/0", MOTOR_ON, MOTOR_DIR);
    end
    wait_on(lat);
    total++;
    if (lat !== 17) begin
      bad++;
      $display("FAIL fwd_off_gap: got %0d want 17", lat);
    end
    total++;
    if (bus.REMAIN !== 16'd0) begin
      bad++;
      $display("FAIL fwd_remain: got %0d want 0", bus.REMAIN);
    end
    step();
    total++;
    if (bus.DONE !== 1'b1 || bus.DONE_ID !== 1'b0 || bus.ABORTED !== 1'b0) begin
      bad++;
      $display("FAIL fwd_done: done=%b id=%b ab=%b want 1/0/0", bus.DONE, bus.DONE_ID,
               bus.ABORTED);
    end
    step();
    total++;
    if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin
      bad++;
      $display("FAIL fwd_after: done=%b busy=%b want 0/0", bus.DONE, bus.BUSY);
    end
    total++;
    if (n_on !== 2 || n_dir !== 0) begin
      bad++;
      $display("FAIL fwd_pulses: on=%0d dir=%0d want 2/0", n_on, n_dir);
    end
  endtask

  task automatic test_reverse();
    int lat;
    logic quiet;
    request(1, 1'b1, 16'd1, lat);
    total++;
    if (bus.GNT !== 2'b10) begin
      bad++;
      $display("FAIL rev_gnt: got %b want 10", bus.GNT);
    end
    step();
    total++;
    if (MOTOR_DIR !== 1'b1 || MOTOR_ON !== 1'b0 || RUN_DIR !== 1'b1) begin
      bad++;
      $display("FAIL rev_dir: dir=%b on=%b run_dir=%b want 1/0/1", MOTOR_DIR, MOTOR_ON,
               RUN_DIR);
    end
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (MOTOR_ON || MOTOR_DIR) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++;
      $display("FAIL rev_settle: pulse seen during settle, want none");
    end
    step();
    total++;
    if (MOTOR_ON !== 1'b1) begin
      bad++;
      $display("FAIL rev_on: got %b want 1", MOTOR_ON);
    end
    wait_on(lat);
    total++;
    if (lat !== 9) begin
      bad++;
      $display("FAIL rev_off_gap: got %0d want 9", lat);
    end
    step();
    total++;
    if (bus.DONE !== 1'b1 || bus.DONE_ID !== 1'b1) begin
      bad++;
      $display("FAIL rev_done: done=%b id=%b want 1/1", bus.DONE, bus.DONE_ID);
    end
    n_dir = 0;
    request(1, 1'b1, 16'd1, lat);
    total++;
    if (lat !== 2 || bus.GNT !== 2'b10) begin
      bad++;
      $display("FAIL rev2_gnt: lat=%0d gnt=%b want 2/10", lat, bus.GNT);
    end
    step();
    total++;
    if (MOTOR_ON !== 1'b1 || MOTOR_DIR !== 1'b0) begin
      bad++;
      $display("FAIL rev2_on: on=%b dir=%b want 1/0", MOTOR_ON, MOTOR_DIR);
    end
    wait_done(lat);
    total++;
    if (lat !== 10 || n_dir !== 0 || RUN_DIR !== 1'b1) begin
      bad++;
      $display("FAIL rev2_done: lat=%0d dirs=%0d run_dir=%b want 10/0/1", lat, n_dir,
               RUN_DIR);
    end
    step();
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g [6];
    int ng;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    exp_g[3] = 2'b10; exp_g[4] = 2'b01; exp_g[5] = 2'b01;
    ng = 0;
    bus.REQ_CNT0 = 16'd0;
    bus.REQ_CNT1 = 16'd0;
    bus.REQ_DIR  = 2'b11;
    bus.REQ      = 2'b11;
    for (int i = 0; i < 80 && ng < 6; i++) begin
      step();
      if (bus.GNT != 2'b00) begin
        total++;
        if (bus.GNT !== exp_g[ng]) begin
          bad++;
          $display("FAIL fair_gnt%0d: got %b want %b", ng, bus.GNT, exp_g[ng]);
        end
        ng++;
        if (ng == 4) bus.REQ[1] = 1'b0;
      end
    end
    bus.REQ = 2'b00;
    total++;
    if (ng !== 6) begin
      bad++;
      $display("FAIL fair_count: got %0d grants want 6", ng);
    end
    for (int i = 0; i < 10 && bus.BUSY; i++) step();
  endtask

  task automatic test_count_zero();
    int lat;
    n_on = 0; n_dir = 0;
    request(0, 1'b0, 16'd0, lat);
    total++;
    if (bus.GNT !== 2'b01) begin
      bad++;
      $display("FAIL zero_gnt: got %b want 01", bus.GNT);
    end
    step();
    total++;
    if (bus.DONE !== 1'b1 || bus.DONE_ID !== 1'b0 || bus.ABORTED !== 1'b0) begin
      bad++;
      $display("FAIL zero_done: done=%b id=%b ab=%b want 1/0/0", bus.DONE, bus.DONE_ID,
               bus.ABORTED);
    end
    step();
    total++;
    if (n_on !== 0 || n_dir !== 0 || dut.on_sh_q !== 1'b0 || RUN_DIR !== 1'b1) begin
      bad++;
      $display("FAIL zero_quiet: on=%0d dir=%0d on_sh=%b run_dir=%b want 0/0/0/1", n_on,
               n_dir, dut.on_sh_q, RUN_DIR);
    end
  endtask

  task automatic test_abort();
    int lat;
    request(0, 1'b1, 16'd5, lat);
    step();
    total++;
    if (MOTOR_ON !== 1'b1) begin
      bad++;
      $display("FAIL abort_on: got %b want 1", MOTOR_ON);
    end
    for (int i = 0; i < 12; i++) step();
    total++;
    if (bus.REMAIN !== 16'd4 || MOTOR_ON !== 1'b0) begin
      bad++;
      $display("FAIL abort_pre: remain=%0d on=%b want 4/0", bus.REMAIN, MOTOR_ON);
    end
    bus.ABORT = 1'b1;
    step();
    bus.ABORT = 1'b0;
    total++;
    if (MOTOR_ON !== 1'b1 || bus.DONE !== 1'b0) begin
      bad++;
      $display("FAIL abort_off: on=%b done=%b want 1/0", MOTOR_ON, bus.DONE);
    end
    step();
    total++;
    if (bus.DONE !== 1'b1 || bus.ABORTED !== 1'b1 || bus.DONE_ID !== 1'b0) begin
      bad++;
      $display("FAIL abort_done: done=%b ab=%b id=%b want 1/1/0", bus.DONE, bus.ABORTED,
               bus.DONE_ID);
    end
    total++;
    if (bus.REMAIN !== 16'd4 || MOTOR_ON !== 1'b0) begin
      bad++;
      $display("FAIL abort_remain: remain=%0d on=%b want 4/0", bus.REMAIN, MOTOR_ON);
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    request(0, 1'b1, 16'd3, lat);
    step();
    for (int i = 0; i < 4; i++) step();
    total++;
    if (bus.BUSY !== 1'b1 || RUN_DIR !== 1'b1 || bus.ABORTED !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre: busy=%b run_dir=%b ab=%b want 1/1/1", bus.BUSY, RUN_DIR,
               bus.ABORTED);
    end
    #3;
    RESET = 1'b1;
    #1;
    total++;
    if (all_outs() !== 26'd0) begin
      bad++;
      $display("FAIL rst_async: got %h want 0", all_outs());
    end
    n_done = 0;
    step();
    step();
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) step();
    total++;
    if (n_done !== 0 || RUN_DIR !== 1'b0 || bus.BUSY !== 1'b0) begin
      bad++;
      $display("FAIL rst_after: dones=%0d run_dir=%b busy=%b want 0/0/0", n_done, RUN_DIR,
               bus.BUSY);
    end
    bus.REQ_CNT0 = 16'd0;
    bus.REQ_CNT1 = 16'd0;
    bus.REQ      = 2'b11;
    step();
    bus.REQ      = 2'b00;
    total++;
    if (bus.GNT !== 2'b01) begin
      bad++;
      $display("FAIL rst_first_tie: got %b want 01", bus.GNT);
    end
    for (int i = 0; i < 10 && bus.BUSY; i++) step();
  endtask

  initial begin
    total = 0; bad = 0;
    n_on = 0; n_dir = 0; n_done = 0;
    RESET = 1'b1;
    bus.REQ = 2'b00;
    bus.REQ_DIR = 2'b00;
    bus.REQ_CNT0 = 16'd0;
    bus.REQ_CNT1 = 16'd0;
    bus.ABORT = 1'b0;
    test_reset();
    test_single_fwd();
    test_reverse();
    test_fairness();
    test_count_zero();
    test_abort();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
